// File: rtl/link_control.sv
// Frame sequencer for datapath: one one-hot command per video frame, draw held
// until draw_done (or a timeout), attack animation spread over several frames.
module link_control #(
  parameter int ATTACK_FRAMES = 8,
  parameter int DRAW_TIMEOUT  = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic frame_tick,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_attack,
  input  logic draw_done,
  output logic init,
  output logic idle,
  output logic attack,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic draw,
  output logic draw_timeout,
  output logic frame_overrun
);

  localparam int AW = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES) : 1;
  localparam int DW = $clog2(DRAW_TIMEOUT);

  typedef enum logic [3:0] {
    S_RST, S_INIT, S_IDLE, S_ATTACK, S_UP, S_DOWN, S_LEFT, S_RIGHT, S_DRAW
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   attack_cnt, attack_cnt_nxt;
  logic            attack_armed, attack_armed_nxt;
  logic [DW-1:0]   draw_cnt;
  logic            draw_last;
  logic            draw_expired;

  assign draw_last    = (draw_cnt == DW'(DRAW_TIMEOUT - 1));
  assign draw_expired = (state == S_DRAW) && draw_last && !draw_done;

  always_comb begin
    state_nxt        = state;
    attack_cnt_nxt   = attack_cnt;
    attack_armed_nxt = attack_armed;
    case (state)
      S_RST:  state_nxt = S_INIT;
      S_INIT: state_nxt = S_DRAW;
      S_IDLE: begin
        if (frame_tick) begin
          // Re-arm only after a frame with attack released: no auto-repeat.
          if (!btn_attack) attack_armed_nxt = 1'b1;
          if (attack_cnt != '0) begin
            state_nxt      = S_ATTACK;
            attack_cnt_nxt = attack_cnt - 1'b1;
          end else if (btn_attack && attack_armed) begin
            state_nxt        = S_ATTACK;
            attack_cnt_nxt   = AW'(ATTACK_FRAMES - 1);
            attack_armed_nxt = 1'b0;
          end else if (btn_up)    state_nxt = S_UP;
          else if (btn_down)      state_nxt = S_DOWN;
          else if (btn_left)      state_nxt = S_LEFT;
          else if (btn_right)     state_nxt = S_RIGHT;
          else                    state_nxt = S_DRAW;
        end
      end
      S_ATTACK, S_UP, S_DOWN, S_LEFT, S_RIGHT: state_nxt = S_DRAW;
      S_DRAW: if (draw_done || draw_last) state_nxt = S_IDLE;
      default: state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_RST;
      attack_cnt    <= '0;
      attack_armed  <= 1'b1;
      draw_cnt      <= '0;
      draw_timeout  <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      state         <= state_nxt;
      attack_cnt    <= attack_cnt_nxt;
      attack_armed  <= attack_armed_nxt;
      // Zero on the first DRAW cycle, counts each DRAW cycle after.
      draw_cnt      <= (state == S_DRAW) ? draw_cnt + 1'b1 : '0;
      draw_timeout  <= draw_timeout | draw_expired;
      frame_overrun <= frame_overrun | (frame_tick && (state != S_IDLE));
    end
  end

  assign init   = (state == S_INIT);
  assign idle   = (state == S_IDLE);
  assign attack = (state == S_ATTACK);
  assign up     = (state == S_UP);
  assign down   = (state == S_DOWN);
  assign left   = (state == S_LEFT);
  assign right  = (state == S_RIGHT);
  assign draw   = (state == S_DRAW);

endmodule

// File: tb/tb_link_control.sv
// Directed table-driven bench for link_control (ATTACK_FRAMES=3, DRAW_TIMEOUT=16).
module tb_link_control;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0, draw_done = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_attack = 1'b0;
  logic init, idle, attack, up, down, left, right, draw, draw_timeout, frame_overrun;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  link_control #(.ATTACK_FRAMES(3), .DRAW_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_attack(btn_attack), .draw_done(draw_done),
    .init(init), .idle(idle), .attack(attack), .up(up), .down(down),
    .left(left), .right(right), .draw(draw),
    .draw_timeout(draw_timeout), .frame_overrun(frame_overrun)
  );

  // {init,idle,attack,up,down,left,right,draw}
  localparam logic [7:0] Z = 8'h00, CI = 8'h80, ID = 8'h40, AT = 8'h20, UP = 8'h10,
                         DN = 8'h08, LF = 8'h04, RT = 8'h02, DR = 8'h01;
  // {up,down,left,right,attack}
  localparam logic [4:0] B_UP = 5'b10000, B_DN = 5'b01000, B_LF = 5'b00100,
                         B_RT = 5'b00010, B_AT = 5'b00001;

  typedef struct {
    logic       tick;
    logic [4:0] btn;
    logic       done;
    logic [7:0] cmd;
    logic       to;
    logic       ov;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic t, input logic [4:0] b, input logic d,
                     input logic [7:0] c, input logic to, input logic ov);
    vec_t v;
    v.tick = t; v.btn = b; v.done = d; v.cmd = c; v.to = to; v.ov = ov;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic t, input logic [4:0] b, input logic d);
    frame_tick = t;
    {btn_up, btn_down, btn_left, btn_right, btn_attack} = b;
    draw_done = d;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] want);
    logic [9:0] got;
    got = {init, idle, attack, up, down, left, right, draw, draw_timeout, frame_overrun};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got cmd/to/ov=%b want=%b", name, got, want);
    end
  endtask

  initial begin
    // Boot, move priority, attack pacing, overrun, timeout.
    add(0, 0, 0, Z, 0, 0);
    add(0, 0, 0, CI, 0, 0);
    repeat (4) add(0, 0, 0, DR, 0, 0);
    add(0, 0, 1, DR, 0, 0);
    add(1, B_UP | B_LF, 0, ID, 0, 0);
    add(0, 0, 0, UP, 0, 0);
    add(0, 0, 1, DR, 0, 0);
    add(1, 0, 0, ID, 0, 0);
    add(0, 0, 1, DR, 0, 0);
    for (int i = 0; i < 3; i++) begin
      add(1, B_AT | B_RT, 0, ID, 0, 0); add(0, 0, 0, AT, 0, 0); add(0, 0, 1, DR, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      add(1, B_AT | B_RT, 0, ID, 0, 0); add(0, 0, 0, RT, 0, 0); add(0, 0, 1, DR, 0, 0);
    end
    add(1, 0, 0, ID, 0, 0);
    add(0, 0, 1, DR, 0, 0);
    add(1, B_AT, 0, ID, 0, 0); add(0, 0, 0, AT, 0, 0); add(0, 0, 1, DR, 0, 0);
    for (int i = 0; i < 2; i++) begin
      add(1, B_DN, 0, ID, 0, 0); add(0, 0, 0, AT, 0, 0); add(0, 0, 1, DR, 0, 0);
    end
    add(1, B_DN, 0, ID, 0, 0);
    add(0, 0, 0, DN, 0, 0);
    add(1, 0, 0, DR, 0, 0);
    add(1, 0, 1, DR, 0, 1);
    add(0, 0, 0, ID, 0, 1);
    add(1, B_LF, 0, ID, 0, 1);
    add(0, 0, 0, LF, 0, 1);
    add(0, 0, 1, DR, 0, 1);
    add(1, 0, 0, ID, 0, 1);
    repeat (16) add(0, 0, 0, DR, 0, 1);
    add(0, 0, 0, ID, 1, 1);
    add(1, 0, 0, ID, 1, 1);
    add(0, 0, 1, DR, 1, 1);
    add(0, 0, 0, ID, 1, 1);

    drive(0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_hold%0d", i), 10'b0);
    end
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].tick, tbl[i].btn, tbl[i].done);
      check($sformatf("vec%0d", i), {tbl[i].cmd, tbl[i].to, tbl[i].ov});
      step();
    end

    // Async reset while in DRAW with two attack frames still pending.
    drive(1, B_AT, 0);
    check("atk2_idle", {ID, 2'b11});
    step();
    drive(0, 0, 0);
    check("atk2_attack", {AT, 2'b11});
    step();
    check("atk2_draw", {DR, 2'b11});
    #3 reset = 1'b0;
    #1 check("async_reset", 10'b0);
    step();
    check("reset_held", 10'b0);
    reset = 1'b1;
    check("post_rst", 10'b0);
    step();
    check("post_init", {CI, 2'b00});
    step();
    drive(0, 0, 1);
    check("post_draw", {DR, 2'b00});
    step();
    drive(1, 0, 0);
    check("post_idle", {ID, 2'b00});
    step();
    drive(0, 0, 1);
    check("cnt_cleared", {DR, 2'b00});
    step();
    drive(1, B_AT, 0);
    check("post_idle2", {ID, 2'b00});
    step();
    drive(0, 0, 0);
    check("armed_after_reset", {AT, 2'b00});
    step();
    check("attack_to_draw", {DR, 2'b00});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/link_control.md
# link_control

Sequencing FSM that drives the one-hot command inputs of `datapath` (init, idle, attack, up, down, left, right, draw) from player buttons and the per-frame tick. It issues exactly one command per frame, holds `draw` until `datapath` reports `draw_done`, and paces the attack animation over several frames. It sits between the input synchronisers and `datapath` in the top level.

## Interface
Parameters:
- ATTACK_FRAMES, 8: number of consecutive frames one attack lasts (≥1).
- DRAW_TIMEOUT, 4096: maximum cycles `draw` is held before abort (≥2).

Ports:
- clock  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- btn_up, btn_down, btn_left, btn_right, btn_attack  in  1 each  synchronised button levels, active-high.
- draw_done  in  1  datapath draw-complete indication.
- init, idle, attack, up, down, left, right, draw  out  1 each  one-hot commands to `datapath`.
- draw_timeout  out  1  sticky: a draw was aborted.
- frame_overrun  out  1  sticky: a frame_tick arrived outside S_IDLE.

## Operation
- States: S_RST, S_INIT, S_IDLE, S_ATTACK, S_UP, S_DOWN, S_LEFT, S_RIGHT, S_DRAW.
- Command outputs are decoded from the state register only (Moore). At most one is high in any cycle. S_RST drives all zeros.
- S_RST → S_INIT unconditionally.
- S_INIT (init=1, 1 cycle) → S_DRAW. This is the initial screen draw.
- S_IDLE (idle=1): stay until frame_tick=1, then pick the next state by priority:
  1. If attack_cnt>0: S_ATTACK, attack_cnt decrements. Movement buttons are ignored.
  2. Else if btn_attack=1 and attack_armed=1: S_ATTACK, attack_cnt←ATTACK_FRAMES−1, attack_armed←0.
  3. Else the first pressed of up > down > left > right selects S_UP/S_DOWN/S_LEFT/S_RIGHT.
  4. Else S_DRAW. The screen is redrawn every frame.
- attack_armed is set when frame_tick is seen in S_IDLE with btn_attack=0. It resets to 1. Holding attack therefore yields one attack, not auto-repeat.
- S_ATTACK and the move states last 1 cycle each, then → S_DRAW.
- S_DRAW (draw=1):
  - On draw_done=1, go to S_IDLE.
  - A counter clears on DRAW entry and increments each DRAW cycle. When it reaches DRAW_TIMEOUT−1 with draw_done=0: go to S_IDLE and set draw_timeout.
  - draw_done sampled in any other state is ignored.
- frame_tick=1 in any state other than S_IDLE sets frame_overrun. That tick is dropped, not queued.
- Sticky flags clear only on reset.

## Timing
- Reset (async assert) forces state=S_RST, all outputs 0, attack_cnt=0, attack_armed=1, draw counter=0, both flags 0.
- After reset release, edge 1 gives S_INIT (init=1) and edge 2 gives S_DRAW.
- frame_tick high in cycle n (S_IDLE):
  - Selected command is high in cycle n+1.
  - For attack/move, draw is high from n+2.
  - With no button, draw is high from n+1.
- draw_done high in cycle m: draw is still high in m, S_IDLE (idle=1) from m+1. draw_done asserted on the same cycle DRAW is entered is honoured.
- Timeout: draw is high for exactly DRAW_TIMEOUT cycles. draw_timeout rises together with idle.
- Simultaneous frame_tick and draw_done in S_DRAW: go to IDLE and set frame_overrun. The tick is not consumed.
- Buttons are sampled only in the frame_tick cycle.

## Test plan
- Reset/boot: hold reset=0 ≥3 cycles, release → outputs all 0 during reset; init=1 at edge 1, draw=1 from edge 2; draw_done after 5 cycles → idle=1 the next cycle.
- Move priority: btn_up=1 and btn_left=1 at frame_tick → up=1 for exactly 1 cycle, then draw=1; left never asserted.
- Attack sequence, ATTACK_FRAMES=3, btn_attack held with btn_right=1 for 6 frames:
  - attack=1 in frames 1–3, right=1 in frames 4–6, attack never re-fires.
  - Releasing for one frame then pressing gives a new attack.
- Draw timeout, DRAW_TIMEOUT=16, draw_done tied 0: draw high for exactly 16 cycles, then idle=1 and draw_timeout=1, staying 1 over later frames.
- Overrun: frame_tick pulsed while in S_DRAW → frame_overrun=1, no extra command issued, next tick in S_IDLE handled normally.
- Async reset mid-DRAW and mid-attack (attack_cnt=2): outputs 0 immediately without a clock edge; after release the sequence restarts at S_INIT with attack_cnt=0.
